// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the
// single-port data SRAM.
// Ports:
//   clk, rst                        - clock, sync active-high reset
//   req/we/addr/wdata 0,1           - requester access inputs
//   ack/err/rdata 0,1               - per-port completion outputs
//   CSram/Direc/Datain/LeerMem/EscrMem, Dataout - SRAM interface
//   busy                            - access in progress
module sram_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 32,
  parameter int MEM_DEPTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic          err0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic          err1,
  output logic [DW-1:0] rdata1,
  output logic          CSram,
  output logic [AW-1:0] Direc,
  output logic [DW-1:0] Datain,
  output logic          LeerMem,
  output logic          EscrMem,
  input  logic [DW-1:0] Dataout,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(MEM_DEPTH);

  state_t state;
  state_t state_nx;

  logic          g;
  logic          last_grant;
  logic          we_l;
  logic          err_l;

  logic          gnt_v;
  logic          gnt_p;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_err;

  // Grant selection: a tie goes to the port that was not
  // granted last time.
  always_comb begin
    gnt_v     = req0 | req1;
    gnt_p     = (req0 & req1) ? ~last_grant : req1;
    sel_we    = gnt_p ? we1 : we0;
    sel_addr  = gnt_p ? addr1 : addr0;
    sel_wdata = gnt_p ? wdata1 : wdata0;
    sel_err   = {1'b0, sel_addr} >= DEPTH_C;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    CSram    = 1'b0;
    LeerMem  = 1'b0;
    EscrMem  = 1'b0;
    busy     = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (gnt_v) begin
          // Bad addresses skip the SRAM cycle entirely.
          state_nx = sel_err ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        CSram    = 1'b1;
        EscrMem  = we_l;
        LeerMem  = ~we_l;
        state_nx = RESP;
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      g          <= 1'b0;
      last_grant <= 1'b1;
      we_l       <= 1'b0;
      err_l      <= 1'b0;
      Direc      <= '0;
      Datain     <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
      if (state == IDLE && gnt_v) begin
        g          <= gnt_p;
        last_grant <= gnt_p;
        we_l       <= sel_we;
        err_l      <= sel_err;
        // Address/data lines keep their old value
        // when the access is rejected.
        if (!sel_err) begin
          Direc  <= sel_addr;
          Datain <= sel_wdata;
        end
      end
      if (state == RESP) begin
        if (g) begin
          ack1 <= 1'b1;
          err1 <= err_l;
          if (!we_l && !err_l) rdata1 <= Dataout;
        end else begin
          ack0 <= 1'b1;
          err0 <= err_l;
          if (!we_l && !err_l) rdata0 <= Dataout;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: vector table, directed
// corner sequences and randomized rounds against a model.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [7:0]  addr [2];
  logic [31:0] wdata [2];
  logic        ack0, err0, ack1, err1;
  logic [31:0] rdata0, rdata1;
  logic        CSram, LeerMem, EscrMem, busy;
  logic [7:0]  Direc;
  logic [31:0] Datain;
  logic [31:0] Dataout;

  logic        pre_en;
  logic [4:0]  pre_a;
  logic [31:0] pre_d;
  logic [31:0] mem [32];
  logic        bad_cs;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sram_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req[0]), .we0(we[0]),
    .addr0(addr[0]), .wdata0(wdata[0]),
    .ack0(ack0), .err0(err0), .rdata0(rdata0),
    .req1(req[1]), .we1(we[1]),
    .addr1(addr[1]), .wdata1(wdata[1]),
    .ack1(ack1), .err1(err1), .rdata1(rdata1),
    .CSram(CSram), .Direc(Direc), .Datain(Datain),
    .LeerMem(LeerMem), .EscrMem(EscrMem),
    .Dataout(Dataout), .busy(busy)
  );

  // SRAM with registered read port.
  initial Dataout = '0;
  initial bad_cs = 1'b0;
  always @(posedge clk) begin
    if (pre_en) mem[pre_a] <= pre_d;
    else if (CSram) begin
      if (Direc >= 8'd32) bad_cs <= 1'b1;
      if (EscrMem) mem[Direc[4:0]] <= Datain;
      if (LeerMem) Dataout <= mem[Direc[4:0]];
    end
  end

  function automatic logic [31:0] init_w(int i);
    if (i == 3) return 32'h11;
    if (i == 7) return 32'h77;
    return 32'hA500_0000 | 32'(i);
  endfunction

  task automatic chk32(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act,
                      input logic exp);
    chk32(nm, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic chki(input string nm, input int act,
                      input int exp);
    chk32(nm, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic check_zero(input string nm);
    chk32({nm, "_ctl"},
          {25'b0, CSram, LeerMem, EscrMem, busy,
           ack0, ack1, err0, err1}, 32'h0);
    chk32({nm, "_direc"}, {24'b0, Direc}, 32'h0);
    chk32({nm, "_datain"}, Datain, 32'h0);
    chk32({nm, "_rd0"}, rdata0, 32'h0);
    chk32({nm, "_rd1"}, rdata1, 32'h0);
  endtask

  // Single access from one port; starts just after an edge.
  task automatic do_access(input bit p, input bit w,
                           input logic [7:0] a,
                           input logic [31:0] d,
                           output int lat, output bit e,
                           output int cs, output int es,
                           output int oth);
    lat = -1; e = 0; cs = 0; es = 0; oth = 0;
    we[p] = w; addr[p] = a; wdata[p] = d; req[p] = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (CSram) cs++;
      if (EscrMem) es++;
      if ((p ? ack0 : ack1)) oth++;
      if ((p ? ack1 : ack0)) begin
        lat = c;
        e = p ? err1 : err0;
        req[p] = 1'b0;
        break;
      end
    end
    req[p] = 1'b0;
  endtask

  typedef struct {
    bit          p;
    bit          w;
    logic [7:0]  a;
    logic [31:0] d;
    bit          err;
    logic [31:0] rd0;
    logic [31:0] rd1;
    int          cs;
    int          es;
  } vec_t;

  typedef struct {
    bit          p;
    int          cyc;
    bit          e;
    logic [31:0] rd;
  } ev_t;

  vec_t        vt [10];
  ev_t         ex [2];
  ev_t         ob [4];
  int          nex, nob, lat, cs, es, oth, cyc, vcnt, acks;
  bit          e, first, p, mlast;
  logic [1:0]  mode;
  logic [31:0] mmem [32];
  logic [31:0] mrd [2];

  initial begin
    vt[0] = '{0, 1, 8'd5,  32'hDEADBEEF, 0, 32'h0, 32'h0, 1, 1};
    vt[1] = '{0, 0, 8'd5,  32'h0, 0, 32'hDEADBEEF, 32'h0, 1, 0};
    vt[2] = '{1, 0, 8'd3,  32'h0, 0, 32'hDEADBEEF, 32'h11, 1, 0};
    vt[3] = '{1, 0, 8'd32, 32'h0, 1, 32'hDEADBEEF, 32'h11, 0, 0};
    vt[4] = '{1, 0, 8'd31, 32'h0, 0, 32'hDEADBEEF,
              init_w(31), 1, 0};
    vt[5] = '{1, 1, 8'd31, 32'h12345678, 0, 32'hDEADBEEF,
              init_w(31), 1, 1};
    vt[6] = '{0, 0, 8'd31, 32'h0, 0, 32'h12345678,
              init_w(31), 1, 0};
    vt[7] = '{0, 0, 8'd255, 32'h0, 1, 32'h12345678,
              init_w(31), 0, 0};
    vt[8] = '{0, 1, 8'd40, 32'h5555, 1, 32'h12345678,
              init_w(31), 0, 0};
    vt[9] = '{1, 0, 8'd0,  32'h0, 0, 32'h12345678,
              init_w(0), 1, 0};

    req = 2'b00; we = 2'b00;
    addr[0] = '0; addr[1] = '0;
    wdata[0] = '0; wdata[1] = '0;
    pre_en = 1'b0; pre_a = '0; pre_d = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) begin
      pre_en = 1'b1;
      pre_a = 5'(i);
      pre_d = init_w(i);
      @(posedge clk); #1;
    end
    pre_en = 1'b0;
    rst = 1'b0;
    check_zero("reset");

    // Both ports contending from reset: 0,1,0,1.
    we = 2'b00; addr[0] = 8'd3; addr[1] = 8'd7;
    req = 2'b11;
    acks = 0;
    for (int c = 1; c <= 20 && acks < 4; c++) begin
      @(posedge clk); #1;
      if (ack0 && ack1) chk1("dual_ack", 1'b1, 1'b0);
      if (ack0 || ack1) begin
        ob[acks] = '{ack1, c, 1'b0, ack1 ? rdata1 : rdata0};
        acks++;
        if (acks == 4) req = 2'b00;
      end
    end
    req = 2'b00;
    chki("rr_acks", acks, 4);
    for (int k = 0; k < acks; k++) begin
      chk1("rr_port", ob[k].p, 1'(k % 2));
      chki("rr_cycle", ob[k].cyc, 3 * (k + 1));
      chk32("rr_rdata", ob[k].rd,
            (k % 2 == 1) ? 32'h77 : 32'h11);
    end

    // Vector table of single-port accesses.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      do_access(vt[i].p, vt[i].w, vt[i].a, vt[i].d,
                lat, e, cs, es, oth);
      chki($sformatf("v%0d_lat", i), lat,
           vt[i].err ? 2 : 3);
      chk1($sformatf("v%0d_err", i), e, vt[i].err);
      chk32($sformatf("v%0d_rd0", i), rdata0, vt[i].rd0);
      chk32($sformatf("v%0d_rd1", i), rdata1, vt[i].rd1);
      chki($sformatf("v%0d_cs", i), cs, vt[i].cs);
      chki($sformatf("v%0d_es", i), es, vt[i].es);
      chki($sformatf("v%0d_oth", i), oth, 0);
    end

    // Port 0 holding req: back-to-back grants 3 cycles apart.
    we[0] = 1'b0; addr[0] = 8'd7; req[0] = 1'b1;
    acks = 0;
    for (int c = 1; c <= 15 && acks < 3; c++) begin
      @(posedge clk); #1;
      if (ack1) chk1("hold_ack1", ack1, 1'b0);
      if (ack0) begin
        ob[acks] = '{1'b0, c, err0, rdata0};
        acks++;
        if (acks == 3) req[0] = 1'b0;
      end
    end
    req[0] = 1'b0;
    chki("hold_acks", acks, 3);
    for (int k = 0; k < acks; k++) begin
      chki("hold_cycle", ob[k].cyc, 3 * (k + 1));
      chk32("hold_rdata", ob[k].rd, 32'h77);
    end

    // Reset during the ISSUE cycle of a write.
    we[0] = 1'b1; addr[0] = 8'd9; wdata[0] = 32'hCAFEF00D;
    req[0] = 1'b1;
    @(posedge clk); #1;
    chk1("rst_issue_cs", CSram, 1'b1);
    chk1("rst_issue_wr", EscrMem, 1'b1);
    rst = 1'b1; req[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check_zero("mid_rst");
    acks = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack0) acks++;
    end
    chki("mid_rst_noack", acks, 0);
    do_access(0, 0, 8'd9, 32'h0, lat, e, cs, es, oth);
    chki("mid_rst_lat", lat, 3);
    chk32("mid_rst_rd", rdata0, 32'hCAFEF00D);

    // Randomized rounds against a transaction-level model.
    do_reset();
    for (int i = 0; i < 32; i++) mmem[i] = init_w(i);
    mmem[5]  = 32'hDEADBEEF;
    mmem[31] = 32'h12345678;
    mmem[9]  = 32'hCAFEF00D;
    mrd[0] = '0; mrd[1] = '0;
    mlast = 1'b1;
    for (int r = 0; r < 60; r++) begin
      mode = 2'($urandom_range(1, 3));
      for (int k = 0; k < 2; k++) begin
        we[k] = 1'($urandom_range(0, 1));
        addr[k] = 8'($urandom_range(0, 40));
        wdata[k] = $urandom;
      end
      first = (mode == 2'd3) ? !mlast : mode[1];
      nex = 0; cyc = 0; vcnt = 0;
      for (int k = 0; k < 2; k++) begin
        if (k == 1 && mode != 2'd3) break;
        p = (k == 0) ? first : !first;
        e = addr[p] >= 8'd32;
        if (!e) begin
          vcnt++;
          if (we[p]) mmem[addr[p][4:0]] = wdata[p];
          else mrd[p] = mmem[addr[p][4:0]];
        end
        mlast = p;
        cyc += e ? 2 : 3;
        ex[k] = '{p, cyc, e, mrd[p]};
        nex++;
      end
      req = mode;
      nob = 0; cs = 0;
      for (int c = 1; c <= 14 && nob < nex; c++) begin
        @(posedge clk); #1;
        if (CSram) cs++;
        if (ack0 && ack1) chk1("rnd_dual", 1'b1, 1'b0);
        if (ack0 && nob < 2) begin
          ob[nob] = '{1'b0, c, err0, rdata0};
          nob++;
          req[0] = 1'b0;
        end
        if (ack1 && nob < 2) begin
          ob[nob] = '{1'b1, c, err1, rdata1};
          nob++;
          req[1] = 1'b0;
        end
      end
      req = 2'b00;
      chki("rnd_nack", nob, nex);
      for (int k = 0; k < nob && k < nex; k++) begin
        chk1("rnd_port", ob[k].p, ex[k].p);
        chki("rnd_cycle", ob[k].cyc, ex[k].cyc);
        chk1("rnd_err", ob[k].e, ex[k].e);
        chk32("rnd_rdata", ob[k].rd, ex[k].rd);
      end
      chki("rnd_cs", cs, vcnt);
      chk32("rnd_rd0", rdata0, mrd[0]);
      chk32("rnd_rd1", rdata1, mrd[1]);
    end
    chk1("bad_addr_issued", bad_cs, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
